dropoff_stop_model: RTL and testbench

Cycle-based model of the dropoff train stop and its buffer chests. It sits directly downstream of dropoff_train_station. It consumes that block's train limit L, accepts train dispatches from the depot under a valid/ready handshake, and unloads arriving trains into the buffer at a fixed rate. It produces the C (trains assigned), T (train present) and U (stored units) signals that feed back into dropoff_train_station.

---
 rtl/dropoff_stop_if.sv | 31 +++
 rtl/dropoff_stop_model.sv | 120 ++++++++++++
 tb/tb_dropoff_stop_model.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dropoff_stop_if.sv
`default_nettype none
// ------------------------------------------------------------------------
// dropoff_stop_if : depot/factory-facing bus of the dropoff stop model
// Rev 1.0
// ------------------------------------------------------------------------
interface dropoff_stop_if #(
    parameter int unsigned INT = 31
);
    logic signed [INT:0] l;
    logic                dispatch_valid;
    logic                dispatch_ready;
    logic                arrive;
    logic        [INT:0] drain_req;
    logic        [INT:0] c;
    logic                t;
    logic        [INT:0] u;
    logic        [INT:0] drained;
    logic                unload_done;
    logic                arrive_err;

    modport master (
        output l, dispatch_valid, arrive, drain_req,
        input  dispatch_ready, c, t, u, drained, unload_done, arrive_err
    );

    modport slave (
        input  l, dispatch_valid, arrive, drain_req,
        output dispatch_ready, c, t, u, drained, unload_done, arrive_err
    );
endinterface
`default_nettype wire

// File: rtl/dropoff_stop_model.sv
`default_nettype none
// ------------------------------------------------------------------------
// dropoff_stop_model : dropoff train stop with buffer chest unloading
// Rev 1.0
// ------------------------------------------------------------------------
module dropoff_stop_model #(
    parameter int unsigned W    = 8000,
    parameter int unsigned CAP  = 128000,
    parameter int unsigned RATE = 400,
    parameter int unsigned INT  = 31
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    dropoff_stop_if.slave bus_io
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_UNLOAD  = 2'd1;
    localparam logic [1:0] S_BLOCKED = 2'd2;
    localparam logic [1:0] S_DEPART  = 2'd3;

    localparam logic [INT:0] c_LOAD = (INT+1)'(W);
    localparam logic [INT:0] c_CAP  = (INT+1)'(CAP);
    localparam logic [INT:0] c_RATE = (INT+1)'(RATE);
    localparam logic [INT:0] c_ONE  = (INT+1)'(1);

    logic [1:0]   state_q, state_d;
    logic [INT:0] c_q, c_d;
    logic [INT:0] u_q, u_d;
    logic [INT:0] drained_q;
    logic [INT:0] load_left_q, load_left_d;
    logic         arrive_err_q;

    logic         w_ready, w_accept, w_depart, w_transfer, w_arrive_ok;
    logic [INT:0] w_drain, w_space, w_moved, w_left_after;

    // Drain is taken before the transfer so freed space is usable this cycle.
    always_comb begin
        w_ready     = rst_n && ($signed(c_q) < bus_io.l);
        w_accept    = bus_io.dispatch_valid && w_ready;
        w_depart    = (state_q == S_DEPART);
        w_transfer  = (state_q == S_UNLOAD) || (state_q == S_BLOCKED);
        w_arrive_ok = bus_io.arrive && (state_q == S_IDLE) && (c_q != '0);
        w_drain     = (bus_io.drain_req < u_q) ? bus_io.drain_req : u_q;
        w_space     = c_CAP - (u_q - w_drain);
        w_moved     = '0;
        if (w_transfer) begin
            w_moved = (load_left_q < c_RATE) ? load_left_q : c_RATE;
            if (w_space < w_moved) begin
                w_moved = w_space;
            end
        end
        w_left_after = load_left_q - w_moved;

        c_d = c_q;
        if (w_accept && !w_depart) begin
            c_d = c_q + c_ONE;
        end else if (!w_accept && w_depart) begin
            c_d = c_q - c_ONE;
        end
        u_d         = u_q - w_drain + w_moved;
        load_left_d = w_arrive_ok ? c_LOAD : w_left_after;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_arrive_ok) begin
                    state_d = S_UNLOAD;
                end
            end
            S_UNLOAD, S_BLOCKED: begin
                if (w_left_after == '0) begin
                    state_d = S_DEPART;
                end else if (w_moved == '0) begin
                    state_d = S_BLOCKED;
                end else begin
                    state_d = S_UNLOAD;
                end
            end
            S_DEPART: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus_io.dispatch_ready = w_ready;
        bus_io.t              = (state_q != S_IDLE);
        bus_io.unload_done    = (state_q == S_DEPART);
        bus_io.c              = c_q;
        bus_io.u              = u_q;
        bus_io.drained        = drained_q;
        bus_io.arrive_err     = arrive_err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q          <= '0;
            u_q          <= '0;
            drained_q    <= '0;
            load_left_q  <= '0;
            arrive_err_q <= 1'b0;
        end else begin
            c_q          <= c_d;
            u_q          <= u_d;
            drained_q    <= w_drain;
            load_left_q  <= load_left_d;
            arrive_err_q <= bus_io.arrive && !w_arrive_ok;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dropoff_stop_model.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_dropoff_stop_model : directed bench for the dropoff stop model
// Rev 1.0
// ------------------------------------------------------------------------
module tb_dropoff_stop_model;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   errors = 0;
    int   checks = 0;

    dropoff_stop_if #(.INT(31)) bus_if ();

    dropoff_stop_model #(
        .W(8000), .CAP(8200), .RATE(400), .INT(31)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus_if)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus_if.l              = '0;
        bus_if.dispatch_valid = 1'b0;
        bus_if.arrive         = 1'b0;
        bus_if.drain_req      = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus_if.c !== 32'd0) begin errors++; $display("FAIL rst_c: got %0d want 0", bus_if.c); end
        checks++; if (bus_if.t !== 1'b0) begin errors++; $display("FAIL rst_t: got %b want 0", bus_if.t); end
        checks++; if (bus_if.u !== 32'd0) begin errors++; $display("FAIL rst_u: got %0d want 0", bus_if.u); end
        checks++; if (bus_if.drained !== 32'd0) begin errors++; $display("FAIL rst_drained: got %0d want 0", bus_if.drained); end
        checks++; if (bus_if.unload_done !== 1'b0 || bus_if.arrive_err !== 1'b0) begin errors++; $display("FAIL rst_pulses: got %b%b want 00", bus_if.unload_done, bus_if.arrive_err); end
        bus_if.l = 32'sd5;
        #1;
        checks++; if (bus_if.dispatch_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", bus_if.dispatch_ready); end
        tick();
        rst_n = 1'b1;
        bus_if.l = '0;
    endtask

    task automatic test_dispatch();
        int exp_c;
        int hs;
        do_reset();
        bus_if.l = -32'sd5;
        bus_if.dispatch_valid = 1'b1;
        #1;
        checks++; if (bus_if.dispatch_ready !== 1'b0) begin errors++; $display("FAIL neg_l_ready: got %b want 0", bus_if.dispatch_ready); end
        tick();
        checks++; if (bus_if.c !== 32'd0) begin errors++; $display("FAIL neg_l_c: got %0d want 0", bus_if.c); end
        bus_if.l = 32'sd3;
        exp_c = 0;
        hs = 0;
        for (int k = 1; k <= 6; k++) begin
            #1;
            if (bus_if.dispatch_valid && bus_if.dispatch_ready) hs++;
            checks++; if (bus_if.dispatch_ready !== (exp_c < 3)) begin errors++; $display("FAIL disp_ready[%0d]: got %b want %b", k, bus_if.dispatch_ready, (exp_c < 3)); end
            tick();
            if (exp_c < 3) exp_c++;
            checks++; if (bus_if.c !== exp_c) begin errors++; $display("FAIL disp_c[%0d]: got %0d want %0d", k, bus_if.c, exp_c); end
        end
        bus_if.dispatch_valid = 1'b0;
        checks++; if (hs !== 3) begin errors++; $display("FAIL disp_handshakes: got %0d want 3", hs); end
        checks++; if (bus_if.t !== 1'b0 || bus_if.u !== 32'd0) begin errors++; $display("FAIL disp_tu: got t=%b u=%0d want t=0 u=0", bus_if.t, bus_if.u); end
    endtask

    task automatic test_unload();
        do_reset();
        bus_if.l = 32'sd1;
        bus_if.dispatch_valid = 1'b1;
        tick();
        bus_if.dispatch_valid = 1'b0;
        checks++; if (bus_if.c !== 32'd1) begin errors++; $display("FAIL unl_c: got %0d want 1", bus_if.c); end
        bus_if.arrive = 1'b1;
        tick();
        bus_if.arrive = 1'b0;
        checks++; if (bus_if.t !== 1'b1 || bus_if.u !== 32'd0) begin errors++; $display("FAIL unl_start: got t=%b u=%0d want t=1 u=0", bus_if.t, bus_if.u); end
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++; if (bus_if.u !== 32'(400 * k)) begin errors++; $display("FAIL unl_u[%0d]: got %0d want %0d", k, bus_if.u, 400 * k); end
            checks++; if (bus_if.unload_done !== (k == 20)) begin errors++; $display("FAIL unl_done[%0d]: got %b want %b", k, bus_if.unload_done, (k == 20)); end
        end
        checks++; if (bus_if.t !== 1'b1) begin errors++; $display("FAIL unl_depart_t: got %b want 1", bus_if.t); end
        tick();
        checks++; if (bus_if.t !== 1'b0 || bus_if.c !== 32'd0) begin errors++; $display("FAIL unl_exit: got t=%b c=%0d want t=0 c=0", bus_if.t, bus_if.c); end
        checks++; if (bus_if.u !== 32'd8000 || bus_if.unload_done !== 1'b0) begin errors++; $display("FAIL unl_final: got u=%0d done=%b want u=8000 done=0", bus_if.u, bus_if.unload_done); end
    endtask

    // Continues from the 8000-unit buffer left behind by test_unload.
    task automatic test_blocked();
        bus_if.l = 32'sd1;
        bus_if.dispatch_valid = 1'b1;
        tick();
        bus_if.dispatch_valid = 1'b0;
        bus_if.arrive = 1'b1;
        tick();
        bus_if.arrive = 1'b0;
        tick();
        checks++; if (bus_if.u !== 32'd8200) begin errors++; $display("FAIL blk_first: got u=%0d want 8200", bus_if.u); end
        tick();
        checks++; if (bus_if.u !== 32'd8200 || bus_if.t !== 1'b1 || bus_if.drained !== 32'd0) begin errors++; $display("FAIL blk_hold: got u=%0d t=%b dr=%0d want 8200 1 0", bus_if.u, bus_if.t, bus_if.drained); end
        bus_if.drain_req = 32'd100;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (bus_if.drained !== 32'd100 || bus_if.u !== 32'd8200) begin errors++; $display("FAIL blk_d100[%0d]: got dr=%0d u=%0d want 100 8200", k, bus_if.drained, bus_if.u); end
        end
        bus_if.drain_req = 32'd400;
        for (int k = 0; k < 18; k++) begin
            tick();
            checks++; if (bus_if.unload_done !== 1'b0 || bus_if.u !== 32'd8200) begin errors++; $display("FAIL blk_d400[%0d]: got done=%b u=%0d want 0 8200", k, bus_if.unload_done, bus_if.u); end
        end
        tick();
        checks++; if (bus_if.unload_done !== 1'b1 || bus_if.u !== 32'd8100 || bus_if.drained !== 32'd400) begin errors++; $display("FAIL blk_last: got done=%b u=%0d dr=%0d want 1 8100 400", bus_if.unload_done, bus_if.u, bus_if.drained); end
        bus_if.drain_req = '0;
        tick();
        checks++; if (bus_if.t !== 1'b0 || bus_if.c !== 32'd0 || bus_if.u !== 32'd8100 || bus_if.drained !== 32'd0) begin errors++; $display("FAIL blk_exit: got t=%b c=%0d u=%0d dr=%0d want 0 0 8100 0", bus_if.t, bus_if.c, bus_if.u, bus_if.drained); end
    endtask

    task automatic test_arrive_err();
        do_reset();
        bus_if.arrive = 1'b1;
        tick();
        bus_if.arrive = 1'b0;
        checks++; if (bus_if.arrive_err !== 1'b1 || bus_if.t !== 1'b0) begin errors++; $display("FAIL aerr_idle: got err=%b t=%b want 1 0", bus_if.arrive_err, bus_if.t); end
        tick();
        checks++; if (bus_if.arrive_err !== 1'b0) begin errors++; $display("FAIL aerr_pulse: got %b want 0", bus_if.arrive_err); end
        bus_if.l = 32'sd1;
        bus_if.dispatch_valid = 1'b1;
        tick();
        bus_if.dispatch_valid = 1'b0;
        bus_if.arrive = 1'b1;
        tick();
        bus_if.arrive = 1'b0;
        checks++; if (bus_if.arrive_err !== 1'b0 || bus_if.t !== 1'b1) begin errors++; $display("FAIL aerr_ok: got err=%b t=%b want 0 1", bus_if.arrive_err, bus_if.t); end
        tick();
        bus_if.arrive = 1'b1;
        tick();
        bus_if.arrive = 1'b0;
        checks++; if (bus_if.arrive_err !== 1'b1 || bus_if.u !== 32'd800 || bus_if.c !== 32'd1) begin errors++; $display("FAIL aerr_busy: got err=%b u=%0d c=%0d want 1 800 1", bus_if.arrive_err, bus_if.u, bus_if.c); end
        tick();
        checks++; if (bus_if.arrive_err !== 1'b0 || bus_if.u !== 32'd1200) begin errors++; $display("FAIL aerr_after: got err=%b u=%0d want 0 1200", bus_if.arrive_err, bus_if.u); end
        for (int k = 0; k < 16; k++) tick();
        checks++; if (bus_if.unload_done !== 1'b0 || bus_if.u !== 32'd7600) begin errors++; $display("FAIL aerr_len19: got done=%b u=%0d want 0 7600", bus_if.unload_done, bus_if.u); end
        tick();
        checks++; if (bus_if.unload_done !== 1'b1 || bus_if.u !== 32'd8000) begin errors++; $display("FAIL aerr_len20: got done=%b u=%0d want 1 8000", bus_if.unload_done, bus_if.u); end
        tick();
    endtask

    task automatic test_back_to_back();
        int hs;
        int done_cnt;
        do_reset();
        bus_if.l = 32'sd3;
        bus_if.dispatch_valid = 1'b1;
        tick();
        tick();
        bus_if.dispatch_valid = 1'b0;
        checks++; if (bus_if.c !== 32'd2) begin errors++; $display("FAIL b2b_c_pre: got %0d want 2", bus_if.c); end
        bus_if.arrive = 1'b1;
        tick();
        bus_if.arrive = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus_if.unload_done === 1'b1) done_cnt++;
        end
        hs = 0;
        bus_if.dispatch_valid = 1'b1;
        #1;
        if (bus_if.dispatch_valid && bus_if.dispatch_ready) hs++;
        tick();
        bus_if.dispatch_valid = 1'b0;
        if (bus_if.unload_done === 1'b1) done_cnt++;
        checks++; if (bus_if.c !== 32'd2) begin errors++; $display("FAIL b2b_c: got %0d want 2", bus_if.c); end
        checks++; if (hs !== 1) begin errors++; $display("FAIL b2b_accepts: got %0d want 1", hs); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL b2b_done_cnt: got %0d want 1", done_cnt); end
        checks++; if (bus_if.t !== 1'b0) begin errors++; $display("FAIL b2b_t: got %b want 0", bus_if.t); end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus_if.l = 32'sd2;
        bus_if.dispatch_valid = 1'b1;
        tick();
        bus_if.dispatch_valid = 1'b0;
        bus_if.arrive = 1'b1;
        tick();
        bus_if.arrive = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        checks++; if (bus_if.u !== 32'd2000) begin errors++; $display("FAIL ar_u_pre: got %0d want 2000", bus_if.u); end
        bus_if.drain_req = 32'd400;
        tick();
        checks++; if (bus_if.drained !== 32'd400 || bus_if.u !== 32'd2000) begin errors++; $display("FAIL ar_drain: got dr=%0d u=%0d want 400 2000", bus_if.drained, bus_if.u); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus_if.c !== 32'd0 || bus_if.t !== 1'b0) begin errors++; $display("FAIL ar_ct: got c=%0d t=%b want 0 0", bus_if.c, bus_if.t); end
        checks++; if (bus_if.u !== 32'd0 || bus_if.drained !== 32'd0) begin errors++; $display("FAIL ar_ud: got u=%0d dr=%0d want 0 0", bus_if.u, bus_if.drained); end
        checks++; if (bus_if.dispatch_ready !== 1'b0) begin errors++; $display("FAIL ar_ready_low: got %b want 0", bus_if.dispatch_ready); end
        tick();
        bus_if.drain_req = '0;
        #2;
        rst_n = 1'b1;
        #1;
        checks++; if (bus_if.dispatch_ready !== 1'b1) begin errors++; $display("FAIL ar_ready_rel: got %b want 1", bus_if.dispatch_ready); end
        bus_if.l = '0;
        #1;
        checks++; if (bus_if.dispatch_ready !== 1'b0) begin errors++; $display("FAIL ar_ready_l0: got %b want 0", bus_if.dispatch_ready); end
        tick();
        checks++; if (bus_if.c !== 32'd0 || bus_if.t !== 1'b0 || bus_if.u !== 32'd0) begin errors++; $display("FAIL ar_after: got c=%0d t=%b u=%0d want 0 0 0", bus_if.c, bus_if.t, bus_if.u); end
    endtask

    initial begin
        test_reset();
        test_dispatch();
        test_unload();
        test_blocked();
        test_arrive_err();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
